// File: rtl/lcd_text_sequencer_if.sv
// CPU frame-buffer port and LCD-controller write handshake, grouped for the text sequencer.
// The slave modport is the sequencer's view; master is the CPU / LCD-controller side.
interface lcd_text_sequencer_if #(
  parameter int AW = 5
);
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_wdata;
  logic [7:0]    fb_rdata;
  logic          lcd_busy;
  logic          lcd_we;
  logic          lcd_cmd_data;
  logic [7:0]    lcd_data_out;
  logic          refreshing;
  logic          timeout_err;

  modport slave (
    input  fb_we, fb_addr, fb_wdata, lcd_busy,
    output fb_rdata, lcd_we, lcd_cmd_data, lcd_data_out, refreshing, timeout_err
  );

  modport master (
    output fb_we, fb_addr, fb_wdata, lcd_busy,
    input  fb_rdata, lcd_we, lcd_cmd_data, lcd_data_out, refreshing, timeout_err
  );
endinterface

// File: rtl/lcd_text_sequencer.sv
// Frame-buffered text front end for an HD44780 4-bit LCD controller: the CPU writes a
// ROWS x COLS character buffer, dirty rows are repainted autonomously over the busy handshake.
module lcd_text_sequencer #(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_text_sequencer_if.slave   bus
);
  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_ISSUE, S_CMD_ACK, S_CMD_WAIT,
    S_CHR_ISSUE, S_CHR_ACK, S_CHR_WAIT, S_NEXT
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_buf [N];
  logic [ROWS-1:0] r_dirty;
  logic [RW-1:0] r_row, r_last, w_pick, w_wr_row;
  logic [CW-1:0] r_col;
  logic [TW-1:0] r_tmo;
  logic          r_err;
  logic          w_wr_ok, w_any_dirty, w_ack_exp, w_last_col;
  logic [AW-1:0] w_chr_idx;

  function automatic logic [7:0] row_base(input logic [RW-1:0] r);
    case (int'(r))
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  assign w_wr_ok     = bus.fb_we && (int'(bus.fb_addr) < N);
  assign w_wr_row    = RW'(int'(bus.fb_addr) / COLS);
  assign w_any_dirty = |r_dirty;
  assign w_ack_exp   = (r_tmo == TW'(ACK_TIMEOUT));
  assign w_last_col  = (r_col == CW'(COLS - 1));
  assign w_chr_idx   = AW'(int'(r_row) * COLS + int'(r_col));

  // Round-robin: the first dirty row strictly after the last one serviced.
  always_comb begin
    w_pick = '0;
    for (int i = ROWS; i >= 1; i--) begin
      if (r_dirty[(int'(r_last) + i) % ROWS]) w_pick = RW'((int'(r_last) + i) % ROWS);
    end
  end

  // NOTE: the character buffer is reset like ordinary flops because the display must show
  // spaces after reset; that keeps it out of RAM macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_buf[i] <= 8'h20;
    end else if (w_wr_ok) begin
      r_buf[bus.fb_addr] <= bus.fb_wdata;
    end
  end

  assign bus.fb_rdata = (int'(bus.fb_addr) < N) ? r_buf[bus.fb_addr] : 8'h00;

  // NOTE: non-blocking assignments make the later write-set override the earlier
  // refresh-clear when both target the same row in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dirty <= '1;
    end else begin
      if (r_state == S_IDLE && w_any_dirty) r_dirty[w_pick] <= 1'b0;
      if (w_wr_ok) r_dirty[w_wr_row] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_any_dirty)   w_next = S_CMD_ISSUE;
      S_CMD_ISSUE: if (!bus.lcd_busy) w_next = S_CMD_ACK;
      S_CMD_ACK:   if (bus.lcd_busy)  w_next = S_CMD_WAIT;
                   else if (w_ack_exp) w_next = S_CHR_ISSUE;
      S_CMD_WAIT:  if (!bus.lcd_busy) w_next = S_CHR_ISSUE;
      S_CHR_ISSUE: if (!bus.lcd_busy) w_next = S_CHR_ACK;
      S_CHR_ACK:   if (bus.lcd_busy)  w_next = S_CHR_WAIT;
                   else if (w_ack_exp) w_next = S_NEXT;
      S_CHR_WAIT:  if (!bus.lcd_busy) w_next = S_NEXT;
      S_NEXT:      w_next = w_last_col ? S_IDLE : S_CHR_ISSUE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= '0;
      r_last <= RW'(ROWS - 1);
      r_col  <= '0;
      r_tmo  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any_dirty) begin
          r_row  <= w_pick;
          r_last <= w_pick;
          r_col  <= '0;
        end
        S_CMD_ISSUE, S_CHR_ISSUE: if (!bus.lcd_busy) r_tmo <= '0;
        S_CMD_ACK, S_CHR_ACK: if (!bus.lcd_busy) begin
          if (w_ack_exp) r_err <= 1'b1;
          else           r_tmo <= r_tmo + 1'b1;
        end
        S_NEXT: if (!w_last_col) r_col <= r_col + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned,
  // which would infer a latch.
  always_comb begin
    bus.lcd_we       = 1'b0;
    bus.lcd_cmd_data = 1'b0;
    bus.lcd_data_out = 8'h00;
    case (r_state)
      S_CMD_ISSUE: begin
        bus.lcd_we       = !bus.lcd_busy;
        bus.lcd_data_out = 8'h80 | row_base(r_row);
      end
      S_CHR_ISSUE: begin
        bus.lcd_we       = !bus.lcd_busy;
        bus.lcd_cmd_data = 1'b1;
        bus.lcd_data_out = r_buf[w_chr_idx];
      end
      default: ;
    endcase
  end

  assign bus.refreshing  = (r_state != S_IDLE);
  assign bus.timeout_err = r_err;
endmodule
